// File: rtl/ps2_tx_seq_if.sv
// Wishbone slave bus bundle for the PS/2 transmit sequencer.
interface ps2_tx_seq_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [1:0]  wb_sel;
  logic [15:0] wb_adr;
  logic [15:0] wb_wdat;
  logic [15:0] wb_rdat;
  logic        wb_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_wdat,
    input  wb_rdat, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_wdat,
    output wb_rdat, wb_ack
  );
endinterface

// File: rtl/ps2_tx_seq.sv
// PS/2 host-to-device byte transmitter with a Wishbone CSR/DATA register pair.
// Lines are open drain: an *_oe of 1 pulls the line low.
module ps2_tx_seq #(
  parameter int unsigned INHIBIT_CYC = 5000,
  parameter int unsigned TIMEOUT_CYC = 750000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  ps2_tx_seq_if.slave wb,
  output logic        irq,
  input  logic        iack,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe
);

  typedef enum logic [2:0] {
    StIdle, StInhibit, StStart, StData, StParity, StStop, StAck, StWaitHi
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  filt_q;
  logic        fclk_q, fclk_prev_q, fall;
  logic [7:0]  byte_q;
  logic [2:0]  bit_q, bit_d, nxt_bit;
  logic [31:0] inh_cnt_q, tmo_cnt_q;
  logic        ready_q, ready_prev_q, ie_q, tmo_q, nak_q, irq_q, ack_q;
  logic [15:0] rdat_q;
  logic        clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic        bus_req, csr_wr, data_wr, accept;
  logic        inh_done, tmo_active, tmo_hit;
  logic        set_ready, set_nak, set_tmo;
  logic        unused_bus;

  assign bus_req = wb.wb_cyc & wb.wb_stb & ~ack_q;
  assign csr_wr  = bus_req & wb.wb_we & wb.wb_sel[0] & ~wb.wb_adr[1];
  assign data_wr = bus_req & wb.wb_we & wb.wb_sel[0] & wb.wb_adr[1];
  // READY is only ever set in IDLE, so it alone gates a new transfer.
  assign accept  = data_wr & ready_q;

  assign fall       = fclk_prev_q & ~fclk_q;
  assign nxt_bit    = bit_q + 3'd1;
  assign inh_done   = (inh_cnt_q == INHIBIT_CYC - 1);
  assign tmo_active = (state_q == StStart) || (state_q == StData) || (state_q == StParity) ||
                      (state_q == StStop) || (state_q == StAck);
  // Fires on the cycle whose edge would make the count equal TIMEOUT_CYC.
  assign tmo_hit    = tmo_active && (tmo_cnt_q == TIMEOUT_CYC - 1);

  assign unused_bus = ^{wb.wb_adr[15:2], wb.wb_adr[0], wb.wb_wdat[15:8], wb.wb_sel[1]};

  assign wb.wb_ack   = ack_q;
  assign wb.wb_rdat  = rdat_q;
  assign irq         = irq_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a timeout overrides any fall seen in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StInhibit;
      StInhibit: if (inh_done) state_d = StStart;
      StStart:   if (fall) state_d = StData;
      StData:    if (fall && bit_q == 3'd7) state_d = StParity;
      StParity:  if (fall) state_d = StStop;
      StStop:    if (fall) state_d = StAck;
      StAck:     if (fall) state_d = StWaitHi;
      StWaitHi:  if (fclk_q) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (tmo_hit) state_d = StIdle;
  end

  // Output logic: next line drive, bit index and status strobes
  always_comb begin
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    bit_d     = bit_q;
    set_ready = 1'b0;
    set_nak   = 1'b0;
    set_tmo   = 1'b0;
    unique case (state_q)
      StIdle: begin
        clk_oe_d  = accept;
        data_oe_d = 1'b0;
      end
      StInhibit: begin
        if (inh_done) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
        end
      end
      StStart: begin
        if (fall) begin
          data_oe_d = ~byte_q[0];
          bit_d     = 3'd0;
        end
      end
      StData: begin
        if (fall) begin
          if (bit_q == 3'd7) begin
            // Odd parity bit is ~^byte; pulling low means driving its inverse.
            data_oe_d = ^byte_q;
          end else begin
            bit_d     = nxt_bit;
            data_oe_d = ~byte_q[nxt_bit];
          end
        end
      end
      StParity:  if (fall) data_oe_d = 1'b0;
      StStop:    ;
      StAck:     if (fall) set_nak = ps2_data_i;
      StWaitHi:  if (fclk_q) set_ready = 1'b1;
      default:   ;
    endcase
    if (tmo_hit) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      set_tmo   = 1'b1;
      set_ready = 1'b1;
      set_nak   = 1'b0;
    end
  end

  // Datapath: clock filter, counters, shifted byte and line drivers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      filt_q      <= 8'hFF;
      fclk_q      <= 1'b1;
      fclk_prev_q <= 1'b1;
      byte_q      <= 8'h00;
      bit_q       <= 3'd0;
      inh_cnt_q   <= 32'd0;
      tmo_cnt_q   <= 32'd0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
    end else begin
      filt_q      <= {filt_q[6:0], ps2_clk_i};
      fclk_prev_q <= fclk_q;
      if (filt_q == 8'hFF) begin
        fclk_q <= 1'b1;
      end else if (filt_q == 8'h00) begin
        fclk_q <= 1'b0;
      end
      if (accept) byte_q <= wb.wb_wdat[7:0];
      bit_q <= bit_d;
      if (accept) begin
        inh_cnt_q <= 32'd0;
      end else if (state_q == StInhibit) begin
        inh_cnt_q <= inh_cnt_q + 32'd1;
      end
      if (state_q == StInhibit && inh_done) begin
        tmo_cnt_q <= 32'd0;
      end else if (tmo_active) begin
        tmo_cnt_q <= tmo_cnt_q + 32'd1;
      end
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  // Bus side: status bits, interrupt, acknowledge and registered read data
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ready_q      <= 1'b1;
      ready_prev_q <= 1'b1;
      ie_q         <= 1'b0;
      tmo_q        <= 1'b0;
      nak_q        <= 1'b0;
      irq_q        <= 1'b0;
      ack_q        <= 1'b0;
      rdat_q       <= 16'h0000;
    end else begin
      ready_prev_q <= ready_q;
      ack_q        <= bus_req;
      if (accept) begin
        ready_q <= 1'b0;
      end else if (set_ready) begin
        ready_q <= 1'b1;
      end
      if (csr_wr) ie_q <= wb.wb_wdat[6];
      if (accept) begin
        tmo_q <= 1'b0;
      end else if (set_tmo) begin
        tmo_q <= 1'b1;
      end else if (csr_wr && wb.wb_wdat[0]) begin
        tmo_q <= 1'b0;
      end
      if (accept) begin
        nak_q <= 1'b0;
      end else if (set_nak) begin
        nak_q <= 1'b1;
      end else if (csr_wr && wb.wb_wdat[0]) begin
        nak_q <= 1'b0;
      end
      // Arms on READY's rising edge so an acknowledged request stays quiet
      // until the next completion; iack wins over a simultaneous set.
      if (iack) begin
        irq_q <= 1'b0;
      end else if (ie_q && ready_q && !ready_prev_q && !irq_q) begin
        irq_q <= 1'b1;
      end
      if (bus_req) begin
        rdat_q <= wb.wb_adr[1] ? {8'h00, byte_q}
                               : {8'h00, ready_q, ie_q, 4'b0000, tmo_q, nak_q};
      end
    end
  end

endmodule

// File: tb/tb_ps2_tx_seq.sv
// Directed bench for ps2_tx_seq: register vector table plus PS/2 device sequences.
module tb_ps2_tx_seq;
  localparam int unsigned INH  = 20;
  localparam int unsigned TMO  = 2000;
  localparam int unsigned HALF = 20;

  logic clk, rst, irq, iack;
  logic dev_clk, dev_data;
  logic ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  int   total, bad;

  ps2_tx_seq_if wb ();

  // Wired-AND of device and host open-drain drivers
  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  ps2_tx_seq #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb          (wb),
    .irq         (irq),
    .iack        (iack),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired, required event", name);
  endtask

  task automatic bus(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                     input logic [1:0] sel, output logic [15:0] rd);
    @(negedge clk);
    wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = we;
    wb.wb_adr = adr;  wb.wb_wdat = dat; wb.wb_sel = sel;
    @(negedge clk);
    chk("ack_rise", wb.wb_ack, 1);
    rd = wb.wb_rdat;
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", wb.wb_ack, 0);
  endtask

  // Device side of one frame: samples the line before each of the first 11 falls
  // (start, 8 data, parity, stop), then gives one more clock for the ACK sample.
  task automatic device_xfer(input logic ack_low, output logic [10:0] rx);
    int n;
    n = 0;
    rx = '0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      fail_now("start_wait");
      return;
    end
    repeat (10) @(negedge clk);
    for (int f = 0; f < 12; f++) begin
      if (f < 11) rx[f] = ps2_data_i;
      dev_clk = 1'b0;
      if (f == 10 && ack_low) dev_data = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (f == 11) dev_data = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  vec_t        vecs[12];
  logic [15:0] rd;
  logic [10:0] rx;
  int          n;

  initial begin
    total = 0; bad = 0;
    iack = 1'b0; dev_clk = 1'b1; dev_data = 1'b1;
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0; wb.wb_we = 1'b0;
    wb.wb_adr = '0; wb.wb_wdat = '0; wb.wb_sel = '0;

    vecs[0]  = '{1'b0, 16'h0000, 16'h0000, 2'b01, 1'b1, 16'h0080};
    vecs[1]  = '{1'b0, 16'h0002, 16'h0000, 2'b01, 1'b1, 16'h0000};
    vecs[2]  = '{1'b1, 16'h0000, 16'h0040, 2'b01, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 2'b01, 1'b1, 16'h00C0};
    vecs[4]  = '{1'b1, 16'h0000, 16'h0000, 2'b10, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 2'b01, 1'b1, 16'h00C0};
    vecs[6]  = '{1'b1, 16'h0000, 16'h0000, 2'b01, 1'b0, 16'h0000};
    vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 2'b01, 1'b1, 16'h0080};
    vecs[8]  = '{1'b0, 16'hFFFD, 16'h0000, 2'b11, 1'b1, 16'h0080};
    vecs[9]  = '{1'b1, 16'h0002, 16'h0055, 2'b10, 1'b0, 16'h0000};
    vecs[10] = '{1'b0, 16'h0000, 16'h0000, 2'b01, 1'b1, 16'h0080};
    vecs[11] = '{1'b0, 16'hFFFE, 16'h0000, 2'b01, 1'b1, 16'h0000};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ack", wb.wb_ack, 0);

    for (int i = 0; i < 12; i++) begin
      bus(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd);
      if (vecs[i].chk) chk($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    // Held strobe: ack pulses 1,0,1
    @(negedge clk);
    wb.wb_cyc = 1'b1; wb.wb_stb = 1'b1; wb.wb_we = 1'b0; wb.wb_adr = 16'h0000;
    @(negedge clk); chk("held_ack0", wb.wb_ack, 1);
    @(negedge clk); chk("held_ack1", wb.wb_ack, 0);
    @(negedge clk); chk("held_ack2", wb.wb_ack, 1);
    wb.wb_cyc = 1'b0; wb.wb_stb = 1'b0;
    @(negedge clk);

    // 0xED with device ACK; also measure the inhibit window
    bus(1'b1, 16'h0002, 16'h00ED, 2'b01, rd);
    chk("inh_data_oe", ps2_data_oe, 0);
    n = 0;
    while (ps2_clk_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("inh_len", n, INH - 1);
    chk("start_data_oe", ps2_data_oe, 1);
    device_xfer(1'b1, rx);
    chk("ed_frame", rx, frame(8'hED));
    chk("ed_frame_lit", rx, 11'b11_11101101_0);
    bus(1'b0, 16'h0000, 16'h0000, 2'b01, rd); chk("ed_csr", rd, 16'h0080);
    bus(1'b0, 16'h0002, 16'h0000, 2'b01, rd); chk("ed_data", rd, 16'h00ED);
    chk("ed_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    // 0x00 with device NAK
    bus(1'b1, 16'h0002, 16'h0000, 2'b01, rd);
    device_xfer(1'b0, rx);
    chk("zero_frame", rx, 11'b11_00000000_0);
    bus(1'b0, 16'h0000, 16'h0000, 2'b01, rd); chk("nak_csr", rd, 16'h0081);
    bus(1'b1, 16'h0000, 16'h0001, 2'b01, rd);
    bus(1'b0, 16'h0000, 16'h0000, 2'b01, rd); chk("nak_clear", rd, 16'h0080);

    // Second DATA write during inhibit is dropped
    bus(1'b1, 16'h0002, 16'h00A5, 2'b01, rd);
    bus(1'b1, 16'h0002, 16'h003C, 2'b01, rd);
    bus(1'b0, 16'h0000, 16'h0000, 2'b01, rd); chk("busy_csr", rd, 16'h0000);
    device_xfer(1'b1, rx);
    chk("a5_frame", rx, frame(8'hA5));
    bus(1'b0, 16'h0002, 16'h0000, 2'b01, rd); chk("a5_data", rd, 16'h00A5);

    // Interrupt on completion, cleared by iack
    bus(1'b1, 16'h0000, 16'h0040, 2'b01, rd);
    bus(1'b1, 16'h0002, 16'h005A, 2'b01, rd);
    chk("irq_busy", irq, 0);
    device_xfer(1'b1, rx);
    chk("irq_frame", rx, frame(8'h5A));
    chk("irq_set", irq, 1);
    iack = 1'b1;
    @(negedge clk);
    iack = 1'b0;
    chk("irq_clr", irq, 0);
    repeat (20) @(negedge clk);
    chk("irq_stays_clr", irq, 0);
    bus(1'b1, 16'h0002, 16'h0011, 2'b01, rd);
    device_xfer(1'b1, rx);
    chk("irq_again", irq, 1);
    iack = 1'b1;
    @(negedge clk);
    iack = 1'b0;
    bus(1'b1, 16'h0000, 16'h0000, 2'b01, rd);

    // Timeout with a silent device
    bus(1'b1, 16'h0002, 16'h0042, 2'b01, rd);
    n = 0;
    while (!ps2_data_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("tmo_start_wait");
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_before", ps2_data_oe, 1);
    @(negedge clk);
    chk("tmo_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    bus(1'b0, 16'h0000, 16'h0000, 2'b01, rd); chk("tmo_csr", rd, 16'h0082);
    bus(1'b1, 16'h0000, 16'h0001, 2'b01, rd);
    bus(1'b0, 16'h0000, 16'h0000, 2'b01, rd); chk("tmo_clear", rd, 16'h0080);

    // Reset in the middle of the DATA phase
    bus(1'b1, 16'h0000, 16'h0040, 2'b01, rd);
    bus(1'b1, 16'h0002, 16'h0000, 2'b01, rd);
    n = 0;
    while (!ps2_data_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int f = 0; f < 3; f++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    chk("mid_data_oe", ps2_data_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    rst = 1'b0;
    bus(1'b0, 16'h0000, 16'h0000, 2'b01, rd); chk("rst_mid_csr", rd, 16'h0080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
